imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, 256, largest accepted word count; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  byte of the load stream.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
REQ-008 start  input  1  one-cycle pulse; re-arms the loader from DONE or ERROR.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  32  word-aligned byte address of the write.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor in reset while high.
REQ-013 done  output  1  image loaded successfully; level output.
REQ-014 error  output  1  load aborted or corrupt; level output.

Function
REQ-015 The FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE and ERR.
REQ-016 Frame format SHALL be: header 0xA5, count N as 2 bytes MSB first, N words as 4 bytes each MSB first (big-endian MIPS), then an optional checksum byte (REQ-029).
REQ-017 IDLE: in_ready=1; byte 0xA5 -> LEN_HI; any other byte is discarded and the state stays IDLE.
REQ-018 LEN_HI and LEN_LO capture N; after LEN_LO: N==0 or N>MAX_WORDS -> ERR, otherwise -> DATA with word counter=0 and byte index=0.
REQ-019 DATA: bytes are shifted into a 32-bit assembly register; on the 4th byte the word is complete.
REQ-020 mem_we SHALL pulse high exactly one cycle after the 4th byte of a word transfers, with mem_wdata equal to that word and mem_addr=BASE_ADDR+4*k for word k.
REQ-021 Address arithmetic SHALL be 32-bit and wrap modulo 2^32 without error.
REQ-022 After word N-1 is written: -> CSUM if checksum is enabled, otherwise -> DONE.
REQ-023 in_ready SHALL be 1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM, and 0 in DONE and ERR.
REQ-024 in_valid low SHALL stall the FSM with no state change; gaps are unbounded.
REQ-025 cpu_hold SHALL be 1 in every state except DONE; done=1 only in DONE; error=1 only in ERR.
REQ-026 A start pulse in DONE or ERR SHALL return the FSM to IDLE and clear the counters; start is ignored in all other states.
REQ-027 A 0xA5 byte inside a frame SHALL be treated as ordinary data, never as a resync.

Reset
REQ-028 reset_n low, including mid-frame, SHALL immediately force IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, error=0, cpu_hold=1, and clear all counters and the checksum accumulator; a partially assembled word is never written.

Configuration
REQ-029 With IMEM_LOADER_CHECKSUM_EN defined, the loader SHALL expect a trailing byte equal to the mod-256 sum of all N*4 data bytes; a match -> DONE, a mismatch -> ERR, and words already written stay written.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN, the CSUM state and the accumulator SHALL be absent, and the frame SHALL end after the last data byte.

Structure
REQ-031 The package imem_loader_pkg SHALL hold the state enum, LOAD_HEADER=8'hA5 and the count width constant (16).
REQ-032 One sub-module, byte_assembler (shifts 4 bytes into a word and flags completion), SHALL be instantiated; the FSM stays in imem_loader.

Verification
REQ-033 Frame A5 00 01 3C 08 00 01 + checksum 0x45 -> one mem_we, addr 0x0, data 0x3C080001, then done=1 and cpu_hold=0.
REQ-034 Frame with N=2 and in_valid deasserted 3 cycles between every byte -> two writes to 0x0 and 0x4, with identical data to the unstalled run.
REQ-035 Count 00 00, or count MAX_WORDS+1 -> error=1, no mem_we, in_ready=0; a start pulse then returns to IDLE.
REQ-036 Leading bytes 00 FF before A5 -> discarded; the frame then loads normally.
REQ-037 reset_n asserted after 2 bytes of word 1 -> no write occurs, outputs take their REQ-028 values, and a following full frame loads correctly.
REQ-038 With the macro defined, a bad checksum -> all words written, then error=1 and cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional trailing checksum is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

    localparam int unsigned COUNT_W     = 16;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned WORD_W      = 32;
    localparam logic [7:0]  LOAD_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    // A word count is usable only if nonzero and within the configured limit.
    function automatic logic len_legal(input logic [COUNT_W-1:0] n,
                                       input int unsigned max_words);
        return (n != '0) && (32'(n) <= max_words);
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Shifts bytes MSB-first into a 32-bit word and flags the cycle the 4th byte arrives.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_shift_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_c,
    output logic              o_complete_c
);

    localparam int unsigned HOLD_W = WORD_W - BYTE_W;

    logic [HOLD_W-1:0] r_shift;
    logic [1:0]        r_idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (i_shift_en) begin
            r_shift <= {r_shift[HOLD_W-BYTE_W-1:0], i_byte};
            r_idx   <= r_idx + 2'd1;
        end
    end

    // The incoming byte completes the word combinationally so it can be captured this edge.
    assign o_word_c     = {r_shift, i_byte};
    assign o_complete_c = i_shift_en && (r_idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses an A5/count/words byte stream and writes instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t               r_state;
    logic [COUNT_W-1:0]   r_len;
    logic [COUNT_W-1:0]   r_word_cnt;
    logic [WORD_W-1:0]    r_waddr;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]    r_csum;
`endif

    logic                 w_xfer;
    logic                 w_shift;
    logic                 w_clear;
    logic                 w_complete;
    logic                 w_last;
    logic [WORD_W-1:0]    w_word;
    logic [COUNT_W-1:0]   w_len_n;

    assign w_xfer  = in_valid && in_ready;
    assign w_shift = w_xfer && (r_state == DATA);
    assign w_clear = start && ((r_state == DONE) || (r_state == ERR));
    assign w_last  = (r_word_cnt == (r_len - COUNT_W'(1)));
    assign w_len_n = {r_len[COUNT_W-1:BYTE_W], in_data};

    byte_assembler u_asm (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_clear      (w_clear),
        .i_shift_en   (w_shift),
        .i_byte       (in_data),
        .o_word_c     (w_word),
        .o_complete_c (w_complete)
    );

    // Frame FSM; handshake and status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_waddr    <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= '0;
`endif
            in_ready   <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= BASE_ADDR;
            mem_wdata  <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_xfer && (in_data == LOAD_HEADER)) begin
                        r_state <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (w_xfer) begin
                        r_len[COUNT_W-1:BYTE_W] <= in_data;
                        r_state                 <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len_n;
                        if (len_legal(w_len_n, MAX_WORDS)) begin
                            r_state    <= DATA;
                            r_word_cnt <= '0;
                            r_waddr    <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_csum     <= '0;
`endif
                        end else begin
                            r_state  <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
                end
                DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_xfer) begin
                        r_csum <= r_csum + in_data;
                    end
`endif
                    if (w_complete) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= r_waddr;
                        mem_wdata  <= w_word;
                        r_waddr    <= r_waddr + WORD_W'(4);
                        r_word_cnt <= r_word_cnt + COUNT_W'(1);
                        if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state  <= CSUM;
`else
                            r_state  <= DONE;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (w_xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state  <= DONE;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            r_state <= ERR;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                DONE, ERR: begin
                    if (start) begin
                        r_state    <= IDLE;
                        r_len      <= '0;
                        r_word_cnt <= '0;
                        r_waddr    <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                        mem_addr   <= BASE_ADDR;
                        in_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader using immediate assertions.
module tb_imem_loader;

    localparam int unsigned MAX_W = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          wr_n      = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(MAX_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            wr_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'hA5;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] n, input logic [31:0] w0, input logic [31:0] w1,
                              input int gap, input logic bad_csum);
        logic [7:0]  cs;
        logic [31:0] w;
        logic [7:0]  b;
        cs = 8'h00;
        send_byte(8'hA5, gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        for (int k = 0; k < int'(n); k++) begin
            w = (k == 0) ? w0 : w1;
            for (int j = 0; j < 4; j++) begin
                b  = 8'(w >> (24 - 8 * j));
                cs = cs + b;
                send_byte(b, gap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? ~cs : cs, gap);
`else
        if (bad_csum) cs = ~cs;
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    int base;

    initial begin
        reset_n  = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single-word frame
        base = wr_n;
        send_frame(16'd1, 32'h3C08_0001, 32'h0, 0, 1'b0);
        settle();
        chk("a_wr_count", 32'(wr_n - base), 32'd1);
        chk("a_addr", wr_addr[base], 32'h0);
        chk("a_data", wr_data[base], 32'h3C08_0001);
        chk("a_done", 32'(done), 32'd1);
        chk("a_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("a_in_ready", 32'(in_ready), 32'd0);
        chk("a_error", 32'(error), 32'd0);
        pulse_start();
        settle();
        chk("start_done", 32'(done), 32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd1);

        // Two words, unstalled; second word contains header bytes as data
        base = wr_n;
        send_frame(16'd2, 32'h1122_3344, 32'hA5A5_0001, 0, 1'b0);
        settle();
        chk("b_wr_count", 32'(wr_n - base), 32'd2);
        chk("b_addr0", wr_addr[base], 32'h0);
        chk("b_data0", wr_data[base], 32'h1122_3344);
        chk("b_addr1", wr_addr[base+1], 32'h4);
        chk("b_data1", wr_data[base+1], 32'hA5A5_0001);
        chk("b_done", 32'(done), 32'd1);
        pulse_start();

        // Same frame with 3-cycle gaps between bytes
        base = wr_n;
        send_frame(16'd2, 32'h1122_3344, 32'hA5A5_0001, 3, 1'b0);
        settle();
        chk("c_wr_count", 32'(wr_n - base), 32'd2);
        chk("c_addr0", wr_addr[base], 32'h0);
        chk("c_data0", wr_data[base], 32'h1122_3344);
        chk("c_addr1", wr_addr[base+1], 32'h4);
        chk("c_data1", wr_data[base+1], 32'hA5A5_0001);
        chk("c_done", 32'(done), 32'd1);
        pulse_start();

        // Leading garbage is discarded
        base = wr_n;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_frame(16'd1, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        settle();
        chk("d_wr_count", 32'(wr_n - base), 32'd1);
        chk("d_addr", wr_addr[base], 32'h0);
        chk("d_data", wr_data[base], 32'hDEAD_BEEF);
        chk("d_done", 32'(done), 32'd1);
        pulse_start();

        // Zero count
        base = wr_n;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        settle();
        chk("z_error", 32'(error), 32'd1);
        chk("z_in_ready", 32'(in_ready), 32'd0);
        chk("z_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("z_done", 32'(done), 32'd0);
        chk("z_no_write", 32'(wr_n - base), 32'd0);
        pulse_start();
        settle();
        chk("z_restart_err", 32'(error), 32'd0);
        chk("z_restart_ready", 32'(in_ready), 32'd1);

        // Count one beyond the limit
        base = wr_n;
        send_byte(8'hA5, 0);
        send_byte(8'(16'(MAX_W + 1) >> 8), 0);
        send_byte(8'(MAX_W + 1), 0);
        settle();
        chk("o_error", 32'(error), 32'd1);
        chk("o_in_ready", 32'(in_ready), 32'd0);
        chk("o_no_write", 32'(wr_n - base), 32'd0);
        pulse_start();
        settle();
        chk("o_restart_err", 32'(error), 32'd0);

        // Reset after two bytes of the second word
        base = wr_n;
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("r_mem_we", 32'(mem_we), 32'd0);
        chk("r_mem_addr", mem_addr, 32'h0);
        chk("r_mem_wdata", mem_wdata, 32'h0);
        chk("r_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("r_in_ready", 32'(in_ready), 32'd1);
        chk("r_done", 32'(done), 32'd0);
        chk("r_error", 32'(error), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        settle();
        chk("r_one_write", 32'(wr_n - base), 32'd1);
        chk("r_first_data", wr_data[base], 32'h0102_0304);
        base = wr_n;
        send_frame(16'd1, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
        settle();
        chk("r2_wr_count", 32'(wr_n - base), 32'd1);
        chk("r2_addr", wr_addr[base], 32'h0);
        chk("r2_data", wr_data[base], 32'hCAFE_F00D);
        chk("r2_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        base = wr_n;
        send_frame(16'd2, 32'h0000_1111, 32'h2222_3333, 0, 1'b1);
        settle();
        chk("k_wr_count", 32'(wr_n - base), 32'd2);
        chk("k_data1", wr_data[base+1], 32'h2222_3333);
        chk("k_error", 32'(error), 32'd1);
        chk("k_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("k_done", 32'(done), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
